// File: rtl/random_share_arbiter.sv
// Round-robin sharing of one LFSR-based, range-limited random source between NUM_REQ requesters.
// Define RANDOM_STATS_EN to build the rejection counter behind stat_reject_cnt.
module random_share_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DSIZE       = 8,
    parameter int unsigned BEGIN_VALUE = 0,
    parameter int unsigned END_VALUE   = 100,
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter int unsigned MAX_RETRY   = 4
) (
    input  logic                       clock,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [DSIZE-1:0]           rsp_data,
    input  logic                       reseed_valid,
    input  logic [15:0]                reseed_data,
    output logic                       busy,
    output logic [15:0]                stat_reject_cnt
);

    localparam int unsigned IDW  = $clog2(NUM_REQ);
    localparam int unsigned RW   = $clog2(MAX_RETRY + 2);
    localparam int unsigned SPAN = END_VALUE - BEGIN_VALUE;

    // Smallest all-ones value covering SPAN; zero when the range is a single value.
    function automatic int unsigned calc_mask(input int unsigned span);
        int unsigned m;
        m = 0;
        for (int i = 0; i < 16; i++) begin
            if (m < span) m = (m << 1) | 32'd1;
        end
        return m;
    endfunction

    localparam int unsigned      MASK_W      = calc_mask(SPAN);
    localparam logic [15:0]      MASK        = MASK_W[15:0];
    localparam logic [15:0]      SPAN16      = SPAN[15:0];
    localparam logic [RW-1:0]    MAX_RETRY_R = MAX_RETRY[RW-1:0];
    localparam logic [DSIZE-1:0] BEGIN_D     = DSIZE'(BEGIN_VALUE);
    localparam logic [DSIZE-1:0] SPAN1_D     = DSIZE'(SPAN + 1);
    localparam logic [IDW:0]     NREQ_W      = (IDW + 1)'(NUM_REQ);
    localparam logic [IDW-1:0]   LAST_ID     = IDW'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        StIdle,
        StArb,
        StDraw,
        StCheck,
        StResp
    } state_t;

    state_t           state_q;
    logic [15:0]      lfsr_q;
    logic [IDW-1:0]   ptr_q;
    logic [IDW-1:0]   id_q;
    logic [RW-1:0]    retry_q;
    logic [DSIZE-1:0] data_q;

    logic             rst_int_n;
    logic [1:0]       rst_sync_q;

    logic [15:0]      lfsr_step;
    logic [15:0]      cand;
    logic             reject;
    logic [DSIZE-1:0] data_acc;
    logic [DSIZE-1:0] data_fold;
    logic             found;
    logic [IDW-1:0]   winner;
    logic [IDW-1:0]   next_ptr;

    // Assert asynchronously, release on a clock edge so all state leaves reset together.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    assign lfsr_step = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign cand      = lfsr_q & MASK;
    assign reject    = cand > SPAN16;
    assign data_acc  = BEGIN_D + DSIZE'(cand);
    // cand < 2*(SPAN+1) after rejection, so the fold always lands inside the range.
    assign data_fold = data_acc - SPAN1_D;

    always_comb begin
        logic [IDW:0] s;
        s      = '0;
        found  = 1'b0;
        winner = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            s = {1'b0, ptr_q} + (IDW + 1)'(i);
            if (s >= NREQ_W) s = s - NREQ_W;
            if (!found && req_valid[s[IDW-1:0]]) begin
                found  = 1'b1;
                winner = s[IDW-1:0];
            end
        end
    end

    assign next_ptr = (winner == LAST_ID) ? '0 : winner + IDW'(1);

    always_comb begin
        req_ready = '0;
        if (state_q == StArb && found) req_ready[winner] = 1'b1;
    end

    assign rsp_valid = (state_q == StResp);
    assign busy      = (state_q != StIdle);
    assign rsp_id    = id_q;
    assign rsp_data  = data_q;

    always_ff @(posedge clock or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q <= StIdle;
            lfsr_q  <= SEED;
            ptr_q   <= '0;
            id_q    <= '0;
            retry_q <= '0;
            data_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (reseed_valid) lfsr_q <= (reseed_data == 16'h0) ? SEED : reseed_data;
                    if (|req_valid) state_q <= StArb;
                end
                StArb: begin
                    if (found) begin
                        id_q    <= winner;
                        ptr_q   <= next_ptr;
                        retry_q <= '0;
                        state_q <= StDraw;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StDraw: begin
                    lfsr_q  <= lfsr_step;
                    state_q <= StCheck;
                end
                StCheck: begin
                    if (!reject) begin
                        data_q  <= data_acc;
                        state_q <= StResp;
                    end else if (retry_q < MAX_RETRY_R) begin
                        retry_q <= retry_q + RW'(1);
                        state_q <= StDraw;
                    end else begin
                        data_q  <= data_fold;
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    if (rsp_ready) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef RANDOM_STATS_EN
    logic [15:0] stat_q;

    always_ff @(posedge clock or negedge rst_int_n) begin
        if (!rst_int_n) begin
            stat_q <= 16'h0;
        end else if (state_q == StIdle && reseed_valid) begin
            stat_q <= 16'h0;
        end else if (state_q == StCheck && reject && stat_q != 16'hFFFF) begin
            stat_q <= stat_q + 16'h1;
        end
    end

    assign stat_reject_cnt = stat_q;
`else
    assign stat_reject_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_random_share_arbiter.sv
// Scoreboard bench for random_share_arbiter: random traffic checked against a behavioural model,
// plus a single-value instance for the fixed-latency case.
module tb_random_share_arbiter;

    localparam int          NR   = 4;
    localparam int          B    = 0;
    localparam int          E    = 100;
    localparam int          MR   = 4;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          clock = 1'b0;
    logic          rst_n;
    logic [NR-1:0] req_valid, req_ready;
    logic          rsp_valid, rsp_ready;
    logic [1:0]    rsp_id;
    logic [7:0]    rsp_data;
    logic          reseed_valid;
    logic [15:0]   reseed_data;
    logic          busy;
    logic [15:0]   stat_reject_cnt;

    logic [3:0]    p_req_valid, p_req_ready;
    logic          p_rsp_valid, p_rsp_ready;
    logic [1:0]    p_rsp_id;
    logic [7:0]    p_rsp_data;
    logic          p_busy;
    logic [15:0]   p_stat;

    random_share_arbiter #(
        .NUM_REQ(NR), .DSIZE(8), .BEGIN_VALUE(B), .END_VALUE(E), .SEED(SEED), .MAX_RETRY(MR)
    ) dut (
        .clock(clock), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .reseed_valid(reseed_valid), .reseed_data(reseed_data), .busy(busy),
        .stat_reject_cnt(stat_reject_cnt)
    );

    random_share_arbiter #(
        .NUM_REQ(4), .DSIZE(8), .BEGIN_VALUE(5), .END_VALUE(5), .SEED(SEED), .MAX_RETRY(MR)
    ) dut_pt (
        .clock(clock), .rst_n(rst_n), .req_valid(p_req_valid), .req_ready(p_req_ready),
        .rsp_valid(p_rsp_valid), .rsp_ready(p_rsp_ready), .rsp_id(p_rsp_id),
        .rsp_data(p_rsp_data), .reseed_valid(1'b0), .reseed_data(16'h0), .busy(p_busy),
        .stat_reject_cnt(p_stat)
    );

    always #5 clock = ~clock;

    typedef struct {
        int id;
        int data;
        int lat;
        int gcyc;
        int stat;
    } exp_t;

    int          checks = 0;
    int          failures = 0;
    exp_t        exp_q[$];
    int          grant_log[$];
    int          rsp_log[$];
    logic [15:0] m_lfsr = SEED;
    int          m_ptr = 0;
    int          m_stat = 0;
    int          cyc = 0;
    bit          rsp_seen = 0;
    int          resp_count = 0;
    int          exp_seq[8];
    int          seq_a[8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // One draw from the model: up to MR+1 tries, then the fold fallback.
    task automatic model_draw(input logic [15:0] l_in, output logic [15:0] l_out,
                              output int data, output int nrej, output int ndraw);
        logic [15:0] l;
        int mask, cand;
        mask = 0;
        while (mask < E - B) mask = mask * 2 + 1;
        l = l_in;
        data = 0;
        nrej = 0;
        ndraw = 0;
        for (int k = 0; k <= MR; k++) begin
            l = lfsr_adv(l);
            ndraw++;
            cand = int'(l) & mask;
            if (cand <= E - B) begin
                data = B + cand;
                break;
            end
            nrej++;
            if (k == MR) data = B + cand - (E - B + 1);
        end
        l_out = l;
    endtask

    task automatic seq_from(input logic [15:0] s);
        logic [15:0] l;
        int d, nr, nd;
        l = s;
        for (int i = 0; i < 8; i++) begin
            model_draw(l, l, d, nr, nd);
            exp_seq[i] = d;
        end
    endtask

    // Monitor: grants push expectations, responses pop and compare.
    int          mon_w, mon_act, mon_d, mon_nr, mon_nd;
    logic [15:0] mon_l;
    exp_t        mon_e;

    always @(negedge clock) begin
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            m_lfsr   = SEED;
            m_ptr    = 0;
            m_stat   = 0;
            rsp_seen = 0;
        end else begin
            if (req_ready != '0) begin
                mon_w = -1;
                for (int i = 0; i < NR; i++)
                    if (mon_w < 0 && req_valid[(m_ptr + i) % NR]) mon_w = (m_ptr + i) % NR;
                mon_act = -1;
                for (int i = 0; i < NR; i++) if (req_ready[i]) mon_act = i;
                check("grant_onehot", $countones(req_ready), 1);
                check("grant_id", mon_act, mon_w);
                grant_log.push_back(mon_act);
                if (mon_w < 0) mon_w = mon_act;
                m_ptr = (mon_w + 1) % NR;
                model_draw(m_lfsr, mon_l, mon_d, mon_nr, mon_nd);
                m_lfsr = mon_l;
                m_stat = (m_stat + mon_nr > 65535) ? 65535 : m_stat + mon_nr;
                mon_e.id   = mon_w;
                mon_e.data = mon_d;
                mon_e.lat  = 3 + 2 * (mon_nd - 1);
                mon_e.gcyc = cyc;
`ifdef RANDOM_STATS_EN
                mon_e.stat = m_stat;
`else
                mon_e.stat = 0;
`endif
                exp_q.push_back(mon_e);
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_spurious actual=rsp_valid=1 expected=no response pending");
                end else begin
                    mon_e = exp_q[0];
                    check("rsp_id", int'(rsp_id), mon_e.id);
                    check("rsp_data", int'(rsp_data), mon_e.data);
                    check("rsp_in_range", (int'(rsp_data) >= B && int'(rsp_data) <= E) ? 1 : 0, 1);
                    check("resp_no_grant", int'(req_ready), 0);
                    check("resp_busy", int'(busy), 1);
                    if (!rsp_seen) begin
                        check("latency", cyc - mon_e.gcyc, mon_e.lat);
                        rsp_seen = 1;
                    end
                    if (rsp_ready) begin
                        check("stat_reject_cnt", int'(stat_reject_cnt), mon_e.stat);
                        rsp_log.push_back(int'(rsp_data));
                        void'(exp_q.pop_front());
                        rsp_seen = 0;
                        resp_count++;
                    end
                end
            end
        end
    end

    // One driver cycle: granted bits drop, idle bits raise with p_req percent chance.
    task automatic drive_step(input int p_req, input int p_rdy);
        logic [NR-1:0] g;
        @(negedge clock);
        g = req_ready;
        @(posedge clock);
        #1;
        req_valid = req_valid & ~g;
        for (int i = 0; i < NR; i++)
            if (int'($urandom_range(99)) < p_req) req_valid[i] = 1'b1;
        rsp_ready = int'($urandom_range(99)) < p_rdy;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy || req_valid != '0) && n < 1000) begin
            drive_step(0, 100);
            n++;
        end
        check("drain_done", (exp_q.size() == 0 && !busy && req_valid == '0) ? 1 : 0, 1);
    endtask

    task automatic reseed(input logic [15:0] d);
        reseed_valid = 1'b1;
        reseed_data  = d;
        m_lfsr = (d == 16'h0) ? SEED : d;
        m_stat = 0;
        @(posedge clock);
        #1;
        reseed_valid = 1'b0;
    endtask

    task automatic run_seq();
        int issued, n;
        rsp_log.delete();
        req_valid = 4'b0001;
        issued = 1;
        n = 0;
        while (rsp_log.size() < 8 && n < 400) begin
            drive_step(0, 100);
            if (req_valid == '0 && issued < 8) begin
                req_valid = 4'b0001;
                issued++;
            end
            n++;
        end
        drain();
        check("seq_len", rsp_log.size(), 8);
    endtask

    initial begin
        int start, n;
        int exp_order[6];
        exp_order = '{0, 1, 2, 3, 0, 1};
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        reseed_valid = 1'b0;
        reseed_data = 16'h0;
        p_req_valid = '0;
        p_rsp_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("reset_req_ready", int'(req_ready), 0);
        check("reset_rsp_valid", int'(rsp_valid), 0);
        check("reset_rsp_id", int'(rsp_id), 0);
        check("reset_rsp_data", int'(rsp_data), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_stat", int'(stat_reject_cnt), 0);
        rst_n = 1'b1;
        repeat (4) @(posedge clock);
        #1;

        // Single-value range: fixed latency, fixed data.
        p_req_valid = 4'b0100;
        @(negedge clock);
        check("pt_c0_no_grant", int'(p_req_ready), 0);
        for (int c = 1; c <= 4; c++) begin
            @(posedge clock);
            #1;
            if (c == 2) p_req_valid = '0;
            @(negedge clock);
            if (c == 1) check("pt_grant", int'(p_req_ready), 4);
            if (c == 2 || c == 3) check("pt_early_rsp", int'(p_rsp_valid), 0);
            if (c == 4) begin
                check("pt_rsp_valid", int'(p_rsp_valid), 1);
                check("pt_rsp_id", int'(p_rsp_id), 2);
                check("pt_rsp_data", int'(p_rsp_data), 5);
                check("pt_stat", int'(p_stat), 0);
            end
        end
        @(posedge clock);
        #1;

        // All requesters held high: strict rotation from pointer 0.
        grant_log.delete();
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        for (n = 0; n < 200 && grant_log.size() < 6; n++) @(negedge clock);
        @(posedge clock);
        #1;
        req_valid = '0;
        check("rr_grant_count", (grant_log.size() >= 6) ? 6 : grant_log.size(), 6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++) check("rr_order", grant_log[i], exp_order[i]);
        drain();

        // Random traffic with random backpressure.
        start = resp_count;
        for (n = 0; n < 30000 && resp_count - start < 1000; n++) drive_step(30, 70);
        drain();
        check("draws_done", (resp_count - start >= 1000) ? 1 : 0, 1);

        // Backpressure in RESP; reseed there must be ignored.
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        for (n = 0; n < 50 && !rsp_valid; n++) drive_step(0, 0);
        check("bp_rsp_seen", int'(rsp_valid), 1);
        req_valid = 4'b1110;
        reseed_valid = 1'b1;
        reseed_data = 16'h1234;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            reseed_valid = 1'b0;
        end
        check("bp_valid_held", int'(rsp_valid), 1);
        check("bp_busy_held", int'(busy), 1);
        drain();

        // Reseed determinism.
        reseed(16'h1234);
        run_seq();
        for (int i = 0; i < 8; i++) seq_a[i] = (i < rsp_log.size()) ? rsp_log[i] : -1;
        seq_from(16'h1234);
        for (int i = 0; i < 8; i++) check("reseed_model_seq", seq_a[i], exp_seq[i]);
        reseed(16'h1234);
        run_seq();
        for (int i = 0; i < 8 && i < rsp_log.size(); i++) check("reseed_repeat", rsp_log[i], seq_a[i]);
        reseed(16'h0000);
        run_seq();
        seq_from(SEED);
        for (int i = 0; i < 8 && i < rsp_log.size(); i++) check("reseed_zero", rsp_log[i], exp_seq[i]);

        // Reset during DRAW aborts the transaction.
        req_valid = 4'b0100;
        for (n = 0; n < 50 && req_ready == '0; n++) @(negedge clock);
        check("pre_reset_grant", int'(req_ready), 4);
        @(posedge clock);
        #1;
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        check("rst_req_ready", int'(req_ready), 0);
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_rsp_id", int'(rsp_id), 0);
        check("rst_rsp_data", int'(rsp_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_stat", int'(stat_reject_cnt), 0);
        repeat (3) @(posedge clock);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        grant_log.delete();
        rsp_log.delete();
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        for (n = 0; n < 50 && grant_log.size() == 0; n++) @(negedge clock);
        @(posedge clock);
        #1;
        req_valid = '0;
        check("post_reset_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
        drain();
        seq_from(SEED);
        check("post_reset_data", (rsp_log.size() > 0) ? rsp_log[0] : -1, exp_seq[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/random_share_arbiter.md
Name: random_share_arbiter

Overview:
- Shares one range-limited pseudo-random source between NUM_REQ requesters.
- Round-robin arbitration picks one requester per draw. A 16-bit LFSR plus a rejection-sampling FSM produces a value in [BEGIN_VALUE, END_VALUE]. The value is returned on a single valid/ready response channel tagged with the requester id.
- Sits between the bounded random source and the stimulus/traffic generators that consume random values.

Parameters:
- NUM_REQ, 4: number of requesters, 2..16.
- DSIZE, 8: result width; END_VALUE < 2^DSIZE, and END_VALUE - BEGIN_VALUE < 2^15.
- BEGIN_VALUE, 0: inclusive lower bound.
- END_VALUE, 100: inclusive upper bound; must be >= BEGIN_VALUE.
- SEED, 16'hACE1: LFSR reset/fallback seed; must be nonzero.
- MAX_RETRY, 4: rejected draws allowed before the fold fallback is used.

Ports:
- clock, input, 1: sole clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- req_valid, input, NUM_REQ: per-requester draw request; held until its req_ready bit pulses.
- req_ready, output, NUM_REQ: one-hot grant pulse, one cycle.
- rsp_valid, output, 1: result available.
- rsp_ready, input, 1: consumer accepts result.
- rsp_id, output, $clog2(NUM_REQ): granted requester index.
- rsp_data, output, DSIZE: random value.
- reseed_valid, input, 1: load reseed_data into the LFSR.
- reseed_data, input, 16: new seed.
- busy, output, 1: high whenever state != IDLE.
- stat_reject_cnt, output, 16: rejection statistics (see Optional Feature).

Behaviour:
- Reset (async assert, sync deassert internally):
  - state = IDLE; LFSR = SEED; RR pointer = 0; retry count = 0.
  - All outputs 0.
- Derived constants:
  - SPAN = END_VALUE - BEGIN_VALUE.
  - MASK = 2^ceil(log2(SPAN+1)) - 1; MASK = 0 when SPAN = 0.
- LFSR step (Fibonacci): fb = l[15]^l[13]^l[12]^l[10]; l <= {l[14:0], fb}. It steps only in DRAW.
- FSM:
  - IDLE:
    - Any req_valid -> ARB.
    - reseed_valid is honoured only in IDLE: load reseed_data, or SEED if reseed_data == 0. It is ignored in all other states.
    - If reseed_valid and req_valid are both high, apply the reseed and go to ARB.
  - ARB:
    - Winner = first set req_valid bit at or after the pointer, wrapping.
    - req_ready[winner] = 1 this cycle only; latch id; pointer <= winner+1 mod NUM_REQ; retry = 0; -> DRAW.
    - If no req_valid (requester dropped), -> IDLE with no grant.
  - DRAW: step LFSR; -> CHECK.
  - CHECK, with cand = l[15:0] & MASK:
    - cand <= SPAN: data = BEGIN_VALUE + cand; -> RESP.
    - else if retry < MAX_RETRY: retry++; -> DRAW.
    - else: data = BEGIN_VALUE + (cand - (SPAN+1)); -> RESP. This is always within range because cand < 2*(SPAN+1).
  - RESP:
    - rsp_valid = 1; rsp_id/rsp_data stay stable until the rsp_valid && rsp_ready cycle, then -> IDLE.
    - No new grant is issued while in RESP.
- Latency:
  - req_valid seen in IDLE at cycle 0: req_ready at cycle 1, rsp_valid at cycle 4 with no rejects.
  - Each reject adds 2 cycles; worst case is 4 + 2*MAX_RETRY.
- rsp_valid may stay high indefinitely under backpressure.
- Reset mid-operation aborts the transaction: no response is issued and the pointer returns to 0.
- Sequence determinism: identical seed and identical grant order give an identical data sequence.

Optional Feature:
- Macro: RANDOM_STATS_EN.
- Defined:
  - stat_reject_cnt counts every CHECK rejection and saturates at 16'hFFFF.
  - It clears on reset and on an honoured reseed.
- Undefined: the counter logic is not built and stat_reject_cnt is tied to 0.
- Functional behaviour is otherwise identical with or without the macro.

Test Plan:
- BEGIN=END=5, single req_valid[2] at cycle 0 -> req_ready[2] at cycle 1; rsp_valid at cycle 4 with rsp_id=2, rsp_data=5; stat_reject_cnt=0.
- All 4 req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0,1; exactly one req_ready bit per grant.
- BEGIN=0, END=100, 1000 draws -> every rsp_data in 0..100; each response within 12 cycles of its grant (MAX_RETRY=4).
- rsp_ready low for 10 cycles during RESP -> rsp_valid, rsp_id and rsp_data stable; no req_ready; busy=1.
- Reseed to 16'h1234 twice with identical request streams -> identical rsp_data sequences; reseed with 0 -> same sequence as from SEED; reseed asserted outside IDLE -> ignored.
- rst_n pulled low during DRAW -> all outputs 0 immediately; after release, the next grant goes to requester 0 first and the data sequence restarts from SEED.
